// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer (master) and
// the processor/host side (slave).
interface instr_sequencer_if #(
  parameter int unsigned INSTR_W = 34,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 4
);
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [PC_W:0]      prog_len;
  logic               start;
  logic [INSTR_W-1:0] instr;
  logic               instr_en;
  logic               done;
  logic [DATA_W-1:0]  data_in1;
  logic [DATA_W-1:0]  data_in2;
  logic [DATA_W-1:0]  data_in3;
  logic               busy;
  logic               halted;
  logic               error;
  logic [PC_W-1:0]    pc;
  logic [PC_W:0]      retired;
  logic               res_valid;
  logic [PC_W-1:0]    res_pc;
  logic [2:0]         res_op;
  logic [DATA_W-1:0]  res_d1;
  logic [DATA_W-1:0]  res_d2;
  logic [DATA_W-1:0]  res_d3;

  modport master (
    input  load_en, load_addr, load_data, prog_len, start, done, data_in1, data_in2, data_in3,
    output instr, instr_en, busy, halted, error, pc, retired,
           res_valid, res_pc, res_op, res_d1, res_d2, res_d3
  );

  modport slave (
    output load_en, load_addr, load_data, prog_len, start, done, data_in1, data_in2, data_in3,
    input  instr, instr_en, busy, halted, error, pc, retired,
           res_valid, res_pc, res_op, res_d1, res_d2, res_d3
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue controller: loadable program memory, one instruction in
// flight over instr/instr_en/done, retire records, halt at program end, stall timeout.
module instr_sequencer #(
  parameter int unsigned INSTR_W = 34,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PC_W    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus_io
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned LenW = PC_W + 1;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StRetire, StHalt, StError} state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_q;
  logic               instr_en_q;
  logic               done_q;
  logic               halted_q;
  logic               error_q;
  logic [PC_W-1:0]    pc_q;
  logic [LenW-1:0]    retired_q;
  logic [LenW-1:0]    len_q;
  logic [CntW-1:0]    cnt_q;
  logic               res_valid_q;
  logic [PC_W-1:0]    res_pc_q;
  logic [2:0]         res_op_q;
  logic [DATA_W-1:0]  res_d1_q;
  logic [DATA_W-1:0]  res_d2_q;
  logic [DATA_W-1:0]  res_d3_q;

  logic            quiescent;
  logic [2:0]      op;
  logic [LenW-1:0] pc_next;

  assign quiescent = (state_q == StIdle) || (state_q == StHalt) || (state_q == StError);
  assign op        = instr_q[INSTR_W-1 -: 3];
  assign pc_next   = LenW'(pc_q) + LenW'(1);

  // Program memory is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (bus_io.load_en && quiescent) begin
      mem_q[bus_io.load_addr] <= bus_io.load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      instr_en_q  <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
      pc_q        <= '0;
      retired_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_pc_q    <= '0;
      res_op_q    <= '0;
      res_d1_q    <= '0;
      res_d2_q    <= '0;
      res_d3_q    <= '0;
    end else begin
      done_q      <= bus_io.done;
      res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StHalt, StError: begin
          if (bus_io.start) begin
            pc_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
            if (bus_io.prog_len == '0) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              halted_q <= 1'b0;
              len_q    <= (bus_io.prog_len > LenW'(DEPTH)) ? LenW'(DEPTH) : bus_io.prog_len;
              state_q  <= StFetch;
            end
          end
        end
        StFetch: begin
          instr_q    <= mem_q[pc_q];
          instr_en_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          if (bus_io.done && !done_q) begin
            instr_en_q  <= 1'b0;
            res_valid_q <= 1'b1;
            res_pc_q    <= pc_q;
            res_op_q    <= op;
            retired_q   <= retired_q + LenW'(1);
            res_d1_q    <= '0;
            res_d2_q    <= '0;
            res_d3_q    <= '0;
            case (op)
              3'b001, 3'b011: res_d1_q <= bus_io.data_in1;
              3'b010, 3'b100: begin
                res_d1_q <= bus_io.data_in1;
                res_d2_q <= bus_io.data_in2;
              end
              3'b101, 3'b110, 3'b111: res_d3_q <= bus_io.data_in3;
              default: ;
            endcase
            state_q <= StRetire;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            // Counter hits TIMEOUT on this edge: exactly TIMEOUT cycles of instr_en.
            instr_en_q <= 1'b0;
            error_q    <= 1'b1;
            state_q    <= StError;
          end
        end
        StRetire: begin
          if (!bus_io.done) begin
            if (pc_next == len_q) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              pc_q    <= pc_next[PC_W-1:0];
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.instr     = instr_q;
  assign bus_io.instr_en  = instr_en_q;
  assign bus_io.busy      = (state_q == StFetch) || (state_q == StWait) || (state_q == StRetire);
  assign bus_io.halted    = halted_q;
  assign bus_io.error     = error_q;
  assign bus_io.pc        = pc_q;
  assign bus_io.retired   = retired_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_pc    = res_pc_q;
  assign bus_io.res_op    = res_op_q;
  assign bus_io.res_d1    = res_d1_q;
  assign bus_io.res_d2    = res_d2_q;
  assign bus_io.res_d3    = res_d3_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program runs, timeout, zero/oversize length,
// load gating, async reset and held-done retire.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.INSTR_W(34), .DATA_W(16), .PC_W(4)) bus ();

  instr_sequencer #(
    .INSTR_W(34), .DATA_W(16), .DEPTH(16), .PC_W(4), .TIMEOUT(64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  localparam logic [15:0] D1 = 16'hA1A1;
  localparam logic [15:0] D2 = 16'hB2B2;
  localparam logic [15:0] D3 = 16'hC3C3;

  int n_vec = 0;
  int n_err = 0;

  // Processor model: mode 0 never answers, 1 answers after 3 cycles, 2 follows manual_done.
  int   mode = 0;
  logic mdone = 1'b0;
  logic manual_done = 1'b0;
  int   en_cnt = 0;
  assign bus.done = (mode == 2) ? manual_done : mdone;

  logic        prev_en = 1'b0;
  int          n_issue = 0;
  int          n_res = 0;
  int          n_overlap = 0;
  logic [33:0] issue_log [256];
  logic [3:0]  rpc_log [256];
  logic [2:0]  rop_log [256];
  logic [15:0] rd1_log [256];
  logic [15:0] rd2_log [256];
  logic [15:0] rd3_log [256];
  logic [33:0] exp_mem [16];
  logic [2:0]  ops [16];

  always @(negedge clk) begin
    if (bus.instr_en && !prev_en) begin
      if (bus.done) n_overlap++;
      if (n_issue < 256) issue_log[n_issue] = bus.instr;
      n_issue++;
    end
    prev_en = bus.instr_en;
    if (bus.res_valid) begin
      if (n_res < 256) begin
        rpc_log[n_res] = bus.res_pc;
        rop_log[n_res] = bus.res_op;
        rd1_log[n_res] = bus.res_d1;
        rd2_log[n_res] = bus.res_d2;
        rd3_log[n_res] = bus.res_d3;
      end
      n_res++;
    end
    if (mode == 1) begin
      if (bus.instr_en && !mdone) begin
        en_cnt++;
        if (en_cnt == 3) begin
          mdone  = 1'b1;
          en_cnt = 0;
        end
      end else if (!bus.instr_en && mdone) begin
        mdone = 1'b0;
      end else if (!bus.instr_en) begin
        en_cnt = 0;
      end
    end else begin
      mdone  = 1'b0;
      en_cnt = 0;
    end
  end

  function automatic logic [33:0] mk(input logic [2:0] op, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [4:0] rd,
                                     input logic [15:0] imm);
    return {op, ra, rb, rd, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [33:0] data);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] len);
    @(negedge clk);
    bus.prog_len = len;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (bus.busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("run_ends", 64'(bus.busy), 64'(0));
  endtask

  task automatic wait_en(input int bound);
    int k = 0;
    while (!bus.instr_en && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("issue_seen", 64'(bus.instr_en), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rbase;
    int k;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.prog_len = '0;  bus.start = 1'b0;
    bus.data_in1 = D1;  bus.data_in2 = D2;  bus.data_in3 = D3;
    ops = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1,
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 16; i++) exp_mem[i] = mk(ops[i], 5'(i), 5'(i + 1), 5'(i + 2), 16'(256 + i));
    exp_mem[0] = mk(3'd0, 5'd0, 5'd0, 5'd1, 16'd17);
    exp_mem[1] = mk(3'd3, 5'd1, 5'd0, 5'd2, 16'hFFF7);
    exp_mem[8] = mk(3'd1, 5'd6, 5'd0, 5'd0, 16'd0);

    // Reset state
    #1 rst = 1'b1;
    #10;
    chk("rst_instr_en", 64'(bus.instr_en), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_halted", 64'(bus.halted), 64'(0));
    chk("rst_error", 64'(bus.error), 64'(0));
    chk("rst_retired", 64'(bus.retired), 64'(0));
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++) load(4'(i), exp_mem[i]);

    // 9-instruction program, with a load to mem[2] attempted while busy
    mode = 1;
    base = n_issue; rbase = n_res;
    @(negedge clk);
    bus.prog_len = 5'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("lat_edge_n_en", 64'(bus.instr_en), 64'(0));
    chk("lat_edge_n_busy", 64'(bus.busy), 64'(1));
    @(posedge clk); #1;
    chk("lat_edge_n1_en", 64'(bus.instr_en), 64'(1));
    chk("lat_edge_n1_instr", 64'(bus.instr), 64'(exp_mem[0]));
    load(4'd2, 34'h0);
    wait_idle(1000);
    chk("p9_res_count", 64'(n_res - rbase), 64'(9));
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("p9_res_pc%0d", i), 64'(rpc_log[rbase + i]), 64'(i));
      chk($sformatf("p9_res_op%0d", i), 64'(rop_log[rbase + i]), 64'(ops[i]));
    end
    chk("p9_op0_d1", 64'(rd1_log[rbase]), 64'(0));
    chk("p9_op3_d1", 64'(rd1_log[rbase + 1]), 64'(D1));
    chk("p9_op3_d2", 64'(rd2_log[rbase + 1]), 64'(0));
    chk("p9_op3_d3", 64'(rd3_log[rbase + 1]), 64'(0));
    chk("p9_op2_d2", 64'(rd2_log[rbase + 2]), 64'(D2));
    chk("p9_op2_d3", 64'(rd3_log[rbase + 2]), 64'(0));
    chk("p9_op5_d1", 64'(rd1_log[rbase + 4]), 64'(0));
    chk("p9_op5_d3", 64'(rd3_log[rbase + 4]), 64'(D3));
    chk("p9_mem2_kept", 64'(issue_log[base + 2]), 64'(exp_mem[2]));
    chk("p9_halted", 64'(bus.halted), 64'(1));
    chk("p9_retired", 64'(bus.retired), 64'(9));
    chk("p9_pc", 64'(bus.pc), 64'(8));
    chk("p9_error", 64'(bus.error), 64'(0));
    chk("p9_no_overlap", 64'(n_overlap), 64'(0));

    // prog_len = 0
    base = n_issue;
    @(negedge clk);
    bus.prog_len = 5'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("len0_halted", 64'(bus.halted), 64'(1));
    chk("len0_busy", 64'(bus.busy), 64'(0));
    repeat (5) @(negedge clk);
    chk("len0_no_issue", 64'(n_issue - base), 64'(0));

    // load mem[0] together with start
    base = n_issue;
    exp_mem[0] = mk(3'd7, 5'd31, 5'd30, 5'd29, 16'hBEEF);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_data = exp_mem[0];
    bus.prog_len = 5'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.load_en = 1'b0; bus.start = 1'b0;
    wait_idle(200);
    chk("simul_first_instr", 64'(issue_log[base]), 64'(exp_mem[0]));
    chk("simul_retired", 64'(bus.retired), 64'(1));

    // prog_len = 20 clamps to 16
    for (int i = 9; i < 16; i++) load(4'(i), exp_mem[i]);
    base = n_issue; rbase = n_res;
    start_run(5'd20);
    wait_idle(2000);
    chk("len20_res_count", 64'(n_res - rbase), 64'(16));
    chk("len20_retired", 64'(bus.retired), 64'(16));
    chk("len20_pc", 64'(bus.pc), 64'(15));
    chk("len20_halted", 64'(bus.halted), 64'(1));
    chk("len20_mem2", 64'(issue_log[base + 2]), 64'(exp_mem[2]));
    chk("len20_mem15", 64'(issue_log[base + 15]), 64'(exp_mem[15]));

    // Timeout
    mode = 0;
    start_run(5'd9);
    wait_en(20);
    k = 0;
    while (bus.instr_en && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("to_en_cycles", 64'(k), 64'(64));
    chk("to_error", 64'(bus.error), 64'(1));
    chk("to_busy", 64'(bus.busy), 64'(0));
    chk("to_retired", 64'(bus.retired), 64'(0));
    mode = 1;
    base = n_issue;
    start_run(5'd2);
    chk("rerun_error_clr", 64'(bus.error), 64'(0));
    chk("rerun_pc", 64'(bus.pc), 64'(0));
    wait_idle(300);
    chk("rerun_first", 64'(issue_log[base]), 64'(exp_mem[0]));
    chk("rerun_retired", 64'(bus.retired), 64'(2));
    chk("rerun_halted", 64'(bus.halted), 64'(1));

    // done held high for 10 cycles after its edge
    mode = 2;
    manual_done = 1'b0;
    rbase = n_res;
    start_run(5'd2);
    wait_en(20);
    @(negedge clk) manual_done = 1'b1;
    repeat (11) @(negedge clk);
    chk("hold_one_res", 64'(n_res - rbase), 64'(1));
    chk("hold_busy", 64'(bus.busy), 64'(1));
    chk("hold_en_low", 64'(bus.instr_en), 64'(0));
    chk("hold_retired", 64'(bus.retired), 64'(1));
    manual_done = 1'b0;
    @(posedge clk); #1;
    chk("hold_edge_a_en", 64'(bus.instr_en), 64'(0));
    @(posedge clk); #1;
    chk("hold_edge_b_en", 64'(bus.instr_en), 64'(1));
    chk("hold_edge_b_pc", 64'(bus.pc), 64'(1));
    @(negedge clk) manual_done = 1'b1;
    @(negedge clk) manual_done = 1'b0;
    wait_idle(200);
    chk("hold_final_retired", 64'(bus.retired), 64'(2));

    // Async reset in the middle of WAIT
    mode = 0;
    start_run(5'd3);
    wait_en(20);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_instr_en", 64'(bus.instr_en), 64'(0));
    chk("arst_instr", 64'(bus.instr), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_pc", 64'(bus.pc), 64'(0));
    chk("arst_error", 64'(bus.error), 64'(0));
    @(negedge clk) rst = 1'b0;
    mode = 1;
    base = n_issue;
    start_run(5'd1);
    wait_idle(200);
    chk("arst_mem_kept", 64'(issue_log[base]), 64'(exp_mem[0]));
    chk("arst_rerun_halted", 64'(bus.halted), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
